conf_int_div__seq__acc_apx: RTL and testbench

Sequential restoring integer divider that inverts the 24-bit configurable multiplier: it takes a 48-bit product-width dividend and a 24-bit divisor and recovers a 48-bit quotient and a 24-bit remainder. Like the multiplier, it has an accurate mode and an approximate mode. The approximate mode drops the low `APX_TRUNC_BITS` of the divisor and the low `2*APX_TRUNC_BITS` of the dividend, so it finishes in fewer cycles. It sits downstream of the multiplier array in the accelerator datapath and is driven by a start/done handshake.

---
 rtl/conf_int_div__seq__acc_apx.sv | 97 +++++++++
 tb/tb_conf_int_div__seq__acc_apx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conf_int_div__seq__acc_apx.sv
// conf_int_div__seq__acc_apx: sequential restoring divider that inverts the configurable multiplier.
// Approximate mode divides a[47:16] by b[23:8] and rescales, finishing in 32 instead of 48 cycles.
module conf_int_div__seq__acc_apx #(
    parameter int DATA_PATH_BITWIDTH = 24,
    parameter int APX_TRUNC_BITS     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            acc__sel,
    input  logic [2*DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0]   b,
    output logic                            busy,
    output logic                            done,
    output logic [2*DATA_PATH_BITWIDTH-1:0] q,
    output logic [DATA_PATH_BITWIDTH-1:0]   r,
    output logic                            dbz
);
    localparam int W  = DATA_PATH_BITWIDTH;
    localparam int DW = 2 * W;
    localparam int T  = APX_TRUNC_BITS;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic            r_acc;
    logic [DW-1:0]   r_dvd;
    logic [W-1:0]    r_dvs;
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    w_bdiv;
    logic            w_bz;
    logic [W:0]      w_pr;
    logic            w_ge;
    logic [W-1:0]    w_rem;
    logic [DW-1:0]   w_qn;

    assign w_bdiv = acc__sel ? b : {{T{1'b0}}, b[W-1:T]};
    assign w_bz   = w_bdiv == '0;
    // q and r double as the quotient shift register and partial remainder while running
    assign w_pr   = {r, r_dvd[DW-1]};
    assign w_ge   = w_pr >= {1'b0, r_dvs};
    assign w_rem  = w_ge ? W'(w_pr - {1'b0, r_dvs}) : w_pr[W-1:0];
    assign w_qn   = {q[DW-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= 1'b0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            q       <= '0;
            r       <= '0;
            dbz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_acc   <= acc__sel;
                        r_dvd   <= acc__sel ? a : {a[DW-1:2*T], {(2*T){1'b0}}};
                        r_dvs   <= w_bdiv;
                        r_cnt   <= acc__sel ? CW'(DW) : CW'(DW - 2*T);
                        q       <= w_bz ? '1 : '0;
                        r       <= '0;
                        dbz     <= w_bz;
                        busy    <= !w_bz;
                        done    <= w_bz;
                        r_state <= w_bz ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    r_dvd <= r_dvd << 1;
                    r_cnt <= r_cnt - 1'b1;
                    q     <= w_qn;
                    r     <= w_rem;
                    if (r_cnt == CW'(1)) begin
                        // approximate quotient is rescaled by 2^T; its remainder is meaningless
                        q       <= r_acc ? w_qn : {{T{1'b0}}, w_qn[DW-2*T-1:0], {T{1'b0}}};
                        r       <= r_acc ? w_rem : '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conf_int_div__seq__acc_apx.sv
// tb_conf_int_div__seq__acc_apx: directed vector table, handshake corner cases and a random sweep.
module tb_conf_int_div__seq__acc_apx;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        acc__sel;
    logic [47:0] a;
    logic [23:0] b;
    logic        busy;
    logic        done;
    logic [47:0] q;
    logic [23:0] r;
    logic        dbz;

    int checks = 0;
    int errors = 0;

    conf_int_div__seq__acc_apx #(.DATA_PATH_BITWIDTH(24), .APX_TRUNC_BITS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .acc__sel(acc__sel), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        acc;
        logic [47:0] a;
        logic [23:0] b;
        logic [47:0] q;
        logic [23:0] r;
        logic        dbz;
        int          n;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic acc_i, input logic [47:0] a_i, input logic [23:0] b_i,
                          output logic [47:0] q_o, output logic [23:0] r_o, output logic dbz_o,
                          output int lat, output int bcnt, output logic one_pulse);
        @(negedge clk);
        acc__sel = acc_i;
        a        = a_i;
        b        = b_i;
        start    = 1'b1;
        lat      = 0;
        bcnt     = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 200);
        q_o   = q;
        r_o   = r;
        dbz_o = dbz;
        @(negedge clk);
        one_pulse = !done;
    endtask

    initial begin
        logic [47:0] qo;
        logic [23:0] ro;
        logic        dbzo;
        logic        pul;
        int          lat;
        int          bc;
        int          dp;
        logic [63:0] rnd;
        logic [47:0] eq;
        logic [23:0] er;
        logic [23:0] bb;
        logic        ez;

        vt[0]  = '{1'b1, 48'd1000000,         24'd7,        48'd142857,          24'd1,   1'b0, 48};
        vt[1]  = '{1'b0, 48'h0000_0300_0000,  24'h000300,   48'h0000_0001_0000,  24'd0,   1'b0, 32};
        vt[2]  = '{1'b1, 48'h0000_0300_0000,  24'h000300,   48'h0000_0001_0000,  24'd0,   1'b0, 48};
        vt[3]  = '{1'b1, 48'd12345,           24'd0,        48'hFFFF_FFFF_FFFF,  24'd0,   1'b1, 0};
        vt[4]  = '{1'b0, 48'd12345,           24'h0000FF,   48'hFFFF_FFFF_FFFF,  24'd0,   1'b1, 0};
        vt[5]  = '{1'b1, 48'hFFFF_FFFF_FFFF,  24'd1,        48'hFFFF_FFFF_FFFF,  24'd0,   1'b0, 48};
        vt[6]  = '{1'b1, 48'd5,               24'hFFFFFF,   48'd0,               24'd5,   1'b0, 48};
        vt[7]  = '{1'b1, 48'hFFFF_FFFF_FFFF,  24'hFFFFFF,   48'h0000_0100_0001,  24'd0,   1'b0, 48};
        vt[8]  = '{1'b0, 48'hFFFF_FFFF_FFFF,  24'h000100,   48'h00FF_FFFF_FF00,  24'd0,   1'b0, 32};
        vt[9]  = '{1'b0, 48'h0000_0064_0000,  24'h000700,   48'h0000_0000_0E00,  24'd0,   1'b0, 32};
        vt[10] = '{1'b1, 48'd100,             24'd7,        48'd14,              24'd2,   1'b0, 48};
        vt[11] = '{1'b1, 48'h1234_5678_9ABC,  24'h000010,   48'h0123_4567_89AB,  24'hC,   1'b0, 48};

        rst = 1'b1; start = 1'b0; acc__sel = 1'b1; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_q", q, 0);
        chk("reset_r", r, 0);
        chk("reset_dbz", dbz, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vt[i].acc, vt[i].a, vt[i].b, qo, ro, dbzo, lat, bc, pul);
            chk($sformatf("vec%0d_q", i), qo, vt[i].q);
            chk($sformatf("vec%0d_r", i), ro, vt[i].r);
            chk($sformatf("vec%0d_dbz", i), dbzo, vt[i].dbz);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].n + 1);
            chk($sformatf("vec%0d_busy_cycles", i), bc, vt[i].n);
            chk($sformatf("vec%0d_done_single", i), pul, 1);
        end

        // start held high throughout; a changes mid-run and only the second op sees it
        @(negedge clk);
        acc__sel = 1'b1; a = 48'd1000000; b = 24'd7; start = 1'b1;
        dp = 0;
        for (int k = 1; k <= 51; k++) begin
            @(negedge clk);
            if (k == 5) a = 48'd700;
            if (done) dp++;
            if (k == 49) begin
                chk("held_done", done, 1);
                chk("held_q", q, 48'd142857);
                chk("held_r", r, 24'd1);
            end
            if (k == 50) begin
                chk("held_gap_busy", busy, 0);
                chk("held_gap_done", done, 0);
            end
            if (k == 51) chk("held_next_accept", busy, 1);
        end
        start = 1'b0;
        chk("held_done_pulses", dp, 1);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("held_second_q", q, 48'd100);
        chk("held_second_r", r, 24'd0);

        // asynchronous abort in the middle of a run
        @(negedge clk);
        acc__sel = 1'b1; a = 48'hFFFF_FFFF_FFFF; b = 24'd1; start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        chk("abort_dbz", dbz, 0);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        rst = 1'b0;
        run_op(vt[0].acc, vt[0].a, vt[0].b, qo, ro, dbzo, lat, bc, pul);
        chk("abort_after_q", qo, vt[0].q);
        chk("abort_after_r", ro, vt[0].r);
        chk("abort_after_latency", lat, 49);

        for (int i = 0; i < 300; i++) begin
            logic        ra;
            logic [47:0] aa;
            logic [23:0] bi;
            ra  = 1'($urandom_range(0, 1));
            rnd = {$urandom(), $urandom()};
            aa  = rnd[47:0];
            bi  = 24'($urandom()) >> $urandom_range(0, 20);
            if (ra) begin
                ez = bi == 0;
                eq = ez ? 48'hFFFF_FFFF_FFFF : aa / {24'd0, bi};
                er = ez ? 24'd0 : 24'(aa % {24'd0, bi});
            end else begin
                bb = bi >> 8;
                ez = bb == 0;
                eq = ez ? 48'hFFFF_FFFF_FFFF : ((aa >> 16) / {24'd0, bb}) << 8;
                er = 24'd0;
            end
            run_op(ra, aa, bi, qo, ro, dbzo, lat, bc, pul);
            chk($sformatf("rand%0d_q", i), qo, eq);
            chk($sformatf("rand%0d_r", i), ro, er);
            chk($sformatf("rand%0d_dbz", i), dbzo, ez);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
